radio_enable_seq: RTL and testbench

- Multi-channel successor to the single-bit timing-engine radio-enable register.
- Per channel, it synchronises an asynchronous enable request into the local clock domain.
- It then sequences the power-amp enable and the radio enable through timed warm-up and cool-down phases.
- A global isolation input clamps all outputs and aborts sequencing, for use at power-domain boundaries.

---
 rtl/radio_seq_pkg.sv | 18 +
 rtl/radio_enable_ch.sv | 89 ++++++++
 rtl/radio_enable_seq.sv | 42 ++++
 tb/tb_radio_enable_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_seq_pkg.sv
// Shared state encoding and counter sizing for the radio enable sequencer.
package radio_seq_pkg;

  typedef enum logic [1:0] {
    RSEQ_OFF,
    RSEQ_WARMUP,
    RSEQ_ON,
    RSEQ_COOLDOWN
  } rseq_state_t;

  // Wide enough to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int warm, input int cool);
    int m;
    m = (warm > cool) ? warm : cool;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/radio_enable_ch.sv
// One radio channel: request synchroniser plus the OFF/WARMUP/ON/COOLDOWN
// sequencer with its phase counter. Outputs the raw registered state.
module radio_enable_ch
  import radio_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int WARMUP_CYC   = 4,
  parameter int COOLDOWN_CYC = 3
) (
  input  logic        ck,
  input  logic        arst_n,
  input  logic        isolate_i,
  input  logic        req_async_i,
  output rseq_state_t state_o
);

  localparam int CNT_W = cnt_width(WARMUP_CYC, COOLDOWN_CYC);
  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  rseq_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], req_async_i};
  assign req_s  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      sync_q  <= '0;
      state_q <= RSEQ_OFF;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Isolation overrides everything; a request fall in WARMUP beats cnt==0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (isolate_i) begin
      state_d = RSEQ_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RSEQ_OFF: begin
          if (req_s) begin
            state_d = RSEQ_WARMUP;
            cnt_d   = WARM_LOAD;
          end
        end
        RSEQ_WARMUP: begin
          if (!req_s) begin
            state_d = RSEQ_COOLDOWN;
            cnt_d   = COOL_LOAD;
          end else if (cnt_q == '0) begin
            state_d = RSEQ_ON;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RSEQ_ON: begin
          if (!req_s) begin
            state_d = RSEQ_COOLDOWN;
            cnt_d   = COOL_LOAD;
          end
        end
        RSEQ_COOLDOWN: begin
          if (cnt_q == '0) begin
            state_d = RSEQ_OFF;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = RSEQ_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/radio_enable_seq.sv
// Multi-channel radio enable sequencer: independent channels with a shared
// combinational isolation clamp on every output.
module radio_enable_seq
  import radio_seq_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int WARMUP_CYC   = 4,
  parameter int COOLDOWN_CYC = 3
) (
  input  logic            ck,
  input  logic            arst_n,
  input  logic            isolate_i,
  input  logic [N_CH-1:0] req_async_i,
  output logic [N_CH-1:0] pa_en_o,
  output logic [N_CH-1:0] radio_en_o,
  output logic [N_CH-1:0] busy_o
);

  rseq_state_t ch_state [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    radio_enable_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .WARMUP_CYC  (WARMUP_CYC),
      .COOLDOWN_CYC(COOLDOWN_CYC)
    ) u_ch (
      .ck         (ck),
      .arst_n     (arst_n),
      .isolate_i  (isolate_i),
      .req_async_i(req_async_i[g]),
      .state_o    (ch_state[g])
    );

    // Clamp acts in the same cycle isolate rises, ahead of the state reset.
    assign pa_en_o[g]    = (ch_state[g] != RSEQ_OFF) & ~isolate_i;
    assign radio_en_o[g] = (ch_state[g] == RSEQ_ON) & ~isolate_i;
    assign busy_o[g]     = ((ch_state[g] == RSEQ_WARMUP) |
                            (ch_state[g] == RSEQ_COOLDOWN)) & ~isolate_i;
  end

endmodule

// File: tb/tb_radio_enable_seq.sv
// Bench for radio_enable_seq: directed scenarios plus randomized traffic,
// all checked against a timestamp-based behavioural model.
module tb_radio_enable_seq;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int WARM = 4;
  localparam int COOL = 3;

  logic            ck = 1'b0;
  logic            arst_n;
  logic            isolate_i;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] pa, radio, busy;

  int n_checks = 0;
  int n_errors = 0;

  radio_enable_seq #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC),
    .WARMUP_CYC  (WARM),
    .COOLDOWN_CYC(COOL)
  ) dut (
    .ck         (ck),
    .arst_n     (arst_n),
    .isolate_i  (isolate_i),
    .req_async_i(req),
    .pa_en_o    (pa),
    .radio_en_o (radio),
    .busy_o     (busy)
  );

  always #5 ck = ~ck;

  // Model: request delay line, plus per channel "powered up since edge X"
  // and "cooling until edge Y" timestamps.
  logic [N_CH-1:0] rq [$];
  bit              m_up   [N_CH];
  bit              m_cool [N_CH];
  int              m_start[N_CH];
  int              m_end  [N_CH];
  int              en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rq.delete();
    for (int i = 0; i < SYNC; i++) rq.push_back('0);
    for (int c = 0; c < N_CH; c++) begin
      m_up[c]   = 1'b0;
      m_cool[c] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    logic [N_CH-1:0] rs;
    if (!arst_n) return;
    en++;
    rs = rq.pop_front();
    rq.push_back(req);
    for (int c = 0; c < N_CH; c++) begin
      if (isolate_i) begin
        m_up[c]   = 1'b0;
        m_cool[c] = 1'b0;
      end else if (m_cool[c]) begin
        if (en == m_end[c]) m_cool[c] = 1'b0;
      end else if (m_up[c]) begin
        if (!rs[c]) begin
          m_up[c]   = 1'b0;
          m_cool[c] = 1'b1;
          m_end[c]  = en + COOL;
        end
      end else if (rs[c]) begin
        m_up[c]    = 1'b1;
        m_start[c] = en;
      end
    end
  endfunction

  function automatic logic [N_CH-1:0] exp_pa();
    logic [N_CH-1:0] v = '0;
    for (int c = 0; c < N_CH; c++) v[c] = (m_up[c] | m_cool[c]) & ~isolate_i;
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_radio();
    logic [N_CH-1:0] v = '0;
    for (int c = 0; c < N_CH; c++) v[c] = m_up[c] && (en - m_start[c] >= WARM) && !isolate_i;
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_busy();
    logic [N_CH-1:0] v = '0;
    for (int c = 0; c < N_CH; c++)
      v[c] = ((m_up[c] && (en - m_start[c] < WARM)) || m_cool[c]) && !isolate_i;
    return v;
  endfunction

  task automatic cmp_all(input string tag);
    check({tag, "_pa"},    32'(pa),    32'(exp_pa()));
    check({tag, "_radio"}, 32'(radio), 32'(exp_radio()));
    check({tag, "_busy"},  32'(busy),  32'(exp_busy()));
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge ck);
      model_edge();
      @(negedge ck);
      cmp_all(tag);
    end
  endtask

  // Reset pulse entirely between two clock edges.
  task automatic async_pulse(input string tag);
    #1 arst_n = 1'b0;
    model_reset();
    #1;
    cmp_all(tag);
    check({tag, "_zero"}, 32'({pa, radio, busy}), 32'(0));
    #1 arst_n = 1'b1;
  endtask

  logic [N_CH-1:0] seen;
  int              cnt;

  initial begin
    arst_n    = 1'b0;
    isolate_i = 1'b0;
    req       = '1;
    en        = 0;
    model_reset();

    // Reset with requests high, then idle.
    step(3, "rst");
    check("rst_outs", 32'({pa, radio, busy}), 32'(0));
    req    = '0;
    arst_n = 1'b1;
    step(20, "idle");
    check("idle_outs", 32'({pa, radio, busy}), 32'(0));

    // Normal sequence on channel 0.
    req = 4'b0001;
    step(3, "norm");
    check("norm_pa_e2",    32'(pa),    32'(4'b0001));
    check("norm_busy_e2",  32'(busy),  32'(4'b0001));
    check("norm_radio_e2", 32'(radio), 32'(4'b0000));
    step(4, "norm");
    check("norm_radio_e6", 32'(radio), 32'(4'b0001));
    check("norm_busy_e6",  32'(busy),  32'(4'b0000));
    step(13, "norm");
    req = '0;
    step(3, "norm");
    check("norm_radio_e22", 32'(radio), 32'(4'b0000));
    check("norm_pa_e22",    32'(pa),    32'(4'b0001));
    step(3, "norm");
    check("norm_pa_e25", 32'(pa), 32'(4'b0000));
    step(5, "norm");

    // Abort in warmup on channel 1.
    req  = 4'b0010;
    seen = '0;
    cnt  = 0;
    step(3, "abort");
    req = '0;
    repeat (10) begin
      step(1, "abort");
      seen |= radio;
      if (pa[1]) cnt++;
    end
    check("abort_radio_seen", 32'(seen), 32'(0));
    check("abort_pa_cycles",  32'(cnt),  32'(5));

    // Re-request during cooldown on channel 2.
    req = 4'b0100;
    step(8, "rereq");
    check("rereq_on", 32'(radio), 32'(4'b0100));
    req = '0;
    step(2, "rereq");
    req = 4'b0100;
    cnt = 0;
    repeat (10) begin
      step(1, "rereq");
      if (!pa[2]) cnt++;
    end
    check("rereq_off_gap", 32'(cnt), 32'(1));

    // Isolation with all channels on.
    req = '1;
    step(10, "iso");
    check("iso_all_on", 32'(radio), 32'(4'hF));
    isolate_i = 1'b1;
    #1;
    cmp_all("iso_clamp");
    check("iso_clamp_zero", 32'({pa, radio, busy}), 32'(0));
    step(3, "iso");
    isolate_i = 1'b0;
    step(1, "iso_rel");
    check("iso_rel_pa",    32'(pa),    32'(4'hF));
    check("iso_rel_busy",  32'(busy),  32'(4'hF));
    check("iso_rel_radio", 32'(radio), 32'(4'h0));
    step(3, "iso_rel");
    check("iso_rel_radio_e3", 32'(radio), 32'(4'h0));
    step(1, "iso_rel");
    check("iso_rel_radio_e4", 32'(radio), 32'(4'hF));

    // Async reset mid-warmup re-incurs the full latency.
    req = '0;
    step(8, "arst");
    req = '1;
    step(3, "arst");
    check("arst_warm", 32'(busy), 32'(4'hF));
    async_pulse("arst_pulse");
    step(2, "arst");
    check("arst_pa_still_off", 32'(pa), 32'(4'h0));
    step(1, "arst");
    check("arst_pa_warm", 32'(pa), 32'(4'hF));
    step(4, "arst");
    check("arst_radio_on", 32'(radio), 32'(4'hF));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5, 0) == 0) req[$urandom_range(N_CH - 1, 0)] ^= 1'b1;
      if (isolate_i) begin
        if ($urandom_range(3, 0) == 0) isolate_i = 1'b0;
      end else if ($urandom_range(39, 0) == 0) begin
        isolate_i = 1'b1;
      end
      if ($urandom_range(149, 0) == 0) async_pulse("rnd_arst");
      step(1, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
